// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
// Opcode encoding, FSM state encoding and field widths.
package spi_cmd_pkg;

  localparam int OPC_W     = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP      = 4'h0,
    OP_SETPOINT = 4'h1,
    OP_KP       = 4'h2,
    OP_CTRL     = 4'h3,
    OP_COMMIT   = 4'h4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_APPLY,
    ST_WAIT_LOW
  } state_e;

endpackage

// File: rtl/spi_valid_sync.sv
// Two-flop synchroniser for the SPI word-valid level plus a rising-edge pulse
// taken on the synchronised level.
module spi_valid_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic v_s1;
  logic v_s2;
  logic v_s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1   <= 1'b0;
      v_s2   <= 1'b0;
      v_s2_d <= 1'b0;
    end else begin
      v_s1   <= din;
      v_s2   <= v_s1;
      v_s2_d <= v_s2;
    end
  end

  assign level = v_s2;
  assign rise  = v_s2 & ~v_s2_d;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes completed SPI words into setpoint / kp / enable register writes.
// Define SPI_CMD_SHADOW_EN to stage writes in shadows applied by a COMMIT opcode.
import spi_cmd_pkg::*;

module spi_cmd_decoder #(
  parameter int WIDTH    = 16,
  parameter int KP_RESET = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic [WIDTH-1:0]       mosi_buffer,
  input  logic                   mosi_buffer_valid,
  output logic [WIDTH-OPC_W-1:0] setpoint,
  output logic [WIDTH-OPC_W-1:0] kp,
  output logic                   ctrl_enable,
  output logic                   cmd_update,
  output logic                   cmd_error,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int DATA_W = WIDTH - OPC_W;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic v_level;
  logic v_rise;

  spi_valid_sync u_sync (
    .clk   (sys_clk),
    .rst   (sys_reset),
    .din   (mosi_buffer_valid),
    .level (v_level),
    .rise  (v_rise)
  );

  state_e state_q;
  state_e state_d;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // WAIT_LOW guarantees one frame per valid assertion however long it is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (v_rise) state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_APPLY;
      ST_APPLY:    state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!v_level) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Stage p0: frame capture (datapath, no reset needed)
  logic [WIDTH-1:0] frame_p0;

  always_ff @(posedge sys_clk) begin
    if (state_q == ST_CAPTURE) frame_p0 <= mosi_buffer;
  end

  opcode_e           opc_p0;
  logic [DATA_W-1:0] data_p0;

  assign opc_p0  = opcode_e'(frame_p0[WIDTH-1 -: OPC_W]);
  assign data_p0 = frame_p0[DATA_W-1:0];

`ifdef SPI_CMD_SHADOW_EN
  logic [DATA_W-1:0] setpoint_sh;
  logic [DATA_W-1:0] kp_sh;
  logic              ctrl_enable_sh;
`endif

  // Stage p1: decode and register update
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      setpoint       <= '0;
      kp             <= DATA_W'(KP_RESET);
      ctrl_enable    <= 1'b0;
      cmd_update     <= 1'b0;
      cmd_error      <= 1'b0;
      err_count      <= '0;
`ifdef SPI_CMD_SHADOW_EN
      setpoint_sh    <= '0;
      kp_sh          <= DATA_W'(KP_RESET);
      ctrl_enable_sh <= 1'b0;
`endif
    end else begin
      cmd_update <= 1'b0;
      cmd_error  <= 1'b0;
      if (state_q == ST_APPLY) begin
        case (opc_p0)
          OP_NOP: ;
`ifdef SPI_CMD_SHADOW_EN
          OP_SETPOINT: setpoint_sh <= data_p0;
          OP_KP:       kp_sh       <= data_p0;
          OP_CTRL: begin
            ctrl_enable_sh <= data_p0[0];
            if (data_p0[1]) err_count <= '0;
          end
          OP_COMMIT: begin
            setpoint    <= setpoint_sh;
            kp          <= kp_sh;
            ctrl_enable <= ctrl_enable_sh;
            cmd_update  <= 1'b1;
          end
`else
          OP_SETPOINT: begin
            setpoint   <= data_p0;
            cmd_update <= 1'b1;
          end
          OP_KP: begin
            kp         <= data_p0;
            cmd_update <= 1'b1;
          end
          OP_CTRL: begin
            ctrl_enable <= data_p0[0];
            cmd_update  <= 1'b1;
            if (data_p0[1]) err_count <= '0;
          end
`endif
          default: begin
            cmd_error <= 1'b1;
            err_count <= sat_inc(err_count);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames plus randomized
// frames compared against a command-level reference model.
module tb_spi_cmd_decoder;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b0;
  logic [15:0] mosi_buffer = '0;
  logic        mosi_buffer_valid = 1'b0;
  logic [11:0] setpoint;
  logic [11:0] kp;
  logic        ctrl_enable;
  logic        cmd_update;
  logic        cmd_error;
  logic [7:0]  err_count;

  spi_cmd_decoder #(.WIDTH(16), .KP_RESET(1)) dut (
    .sys_clk           (sys_clk),
    .sys_reset         (sys_reset),
    .mosi_buffer       (mosi_buffer),
    .mosi_buffer_valid (mosi_buffer_valid),
    .setpoint          (setpoint),
    .kp                (kp),
    .ctrl_enable       (ctrl_enable),
    .cmd_update        (cmd_update),
    .cmd_error         (cmd_error),
    .err_count         (err_count)
  );

  always #5 sys_clk = ~sys_clk;

`ifdef SPI_CMD_SHADOW_EN
  bit shadow_mode = 1'b1;
`else
  bit shadow_mode = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int exp_sp, exp_kp, exp_en, exp_err;
  int sh_sp, sh_kp, sh_en;
  int e_upd, e_errp;
  int total_err_pulses;

  task automatic model_reset();
    exp_sp = 0; exp_kp = 1; exp_en = 0; exp_err = 0;
    sh_sp = 0;  sh_kp = 1;  sh_en = 0;
  endtask

  task automatic model_apply(input logic [15:0] word);
    int op, d;
    op = int'(word) / 4096;
    d  = int'(word) % 4096;
    e_upd = 0; e_errp = 0;
    if (op == 0) begin
      // no effect
    end else if (op >= 1 && op <= 3) begin
      if (op == 1) begin if (shadow_mode) sh_sp = d; else exp_sp = d; end
      if (op == 2) begin if (shadow_mode) sh_kp = d; else exp_kp = d; end
      if (op == 3) begin
        if (shadow_mode) sh_en = d % 2; else exp_en = d % 2;
        if ((d / 2) % 2 == 1) exp_err = 0;
      end
      if (!shadow_mode) e_upd = 1;
    end else if (op == 4 && shadow_mode) begin
      exp_sp = sh_sp; exp_kp = sh_kp; exp_en = sh_en; e_upd = 1;
    end else begin
      e_errp = 1;
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    end
  endtask

  // Valid is assumed high from the current negedge; the next posedge is E0.
  task automatic run_frame(input string name, input logic [15:0] word, input int hold);
    int p_sp, p_kp, p_en, p_err, upd_cnt, err_cnt;
    p_sp = exp_sp; p_kp = exp_kp; p_en = exp_en; p_err = exp_err;
    model_apply(word);
    upd_cnt = 0; err_cnt = 0;
    for (int c = 1; c <= hold; c++) begin
      @(negedge sys_clk);
      if (c == 4) begin
        n_vec++;
        if ({setpoint, kp, ctrl_enable, err_count, cmd_update, cmd_error} !==
            {p_sp[11:0], p_kp[11:0], p_en[0], p_err[7:0], 2'b00}) begin
          n_err++;
          $display("FAIL %s_pre: got sp=%h kp=%h en=%b err=%0d upd=%b erp=%b want sp=%h kp=%h en=%0d err=%0d upd=0 erp=0",
                   name, setpoint, kp, ctrl_enable, err_count, cmd_update, cmd_error, p_sp, p_kp, p_en, p_err);
        end
      end
      if (c == 5) begin
        n_vec++;
        if ({setpoint, kp, ctrl_enable, err_count, cmd_update, cmd_error} !==
            {exp_sp[11:0], exp_kp[11:0], exp_en[0], exp_err[7:0], e_upd[0], e_errp[0]}) begin
          n_err++;
          $display("FAIL %s_e4: got sp=%h kp=%h en=%b err=%0d upd=%b erp=%b want sp=%h kp=%h en=%0d err=%0d upd=%0d erp=%0d",
                   name, setpoint, kp, ctrl_enable, err_count, cmd_update, cmd_error,
                   exp_sp, exp_kp, exp_en, exp_err, e_upd, e_errp);
        end
      end
      upd_cnt += int'(cmd_update);
      err_cnt += int'(cmd_error);
    end
    mosi_buffer_valid = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      upd_cnt += int'(cmd_update);
      err_cnt += int'(cmd_error);
    end
    total_err_pulses += err_cnt;
    n_vec++;
    if (upd_cnt != e_upd || err_cnt != e_errp) begin
      n_err++;
      $display("FAIL %s_pulses: got upd=%0d err=%0d want upd=%0d err=%0d", name, upd_cnt, err_cnt, e_upd, e_errp);
    end
  endtask

  task automatic send_frame(input string name, input logic [15:0] word, input int hold);
    mosi_buffer = word;
    mosi_buffer_valid = 1'b1;
    run_frame(name, word, hold);
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    model_reset();
    n_vec++;
    if ({setpoint, kp, ctrl_enable, cmd_update, cmd_error, err_count} !== {12'h000, 12'h001, 3'b000, 8'h00}) begin
      n_err++;
      $display("FAIL reset: got sp=%h kp=%h en=%b upd=%b erp=%b err=%0d want sp=000 kp=001 en=0 upd=0 erp=0 err=0",
               setpoint, kp, ctrl_enable, cmd_update, cmd_error, err_count);
    end
    sys_reset = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_setpoint();
    send_frame("setpoint", 16'h1ABC, 6);
  endtask

  task automatic test_long_hold();
    send_frame("long_hold", 16'h2123, 50);
  endtask

  task automatic test_error_saturation();
    total_err_pulses = 0;
    for (int i = 0; i < 300; i++) send_frame("err_frame", 16'hF000, 6);
    n_vec++;
    if (total_err_pulses != 300 || err_count !== 8'd255) begin
      n_err++;
      $display("FAIL err_saturate: got pulses=%0d err=%0d want pulses=300 err=255", total_err_pulses, err_count);
    end
    send_frame("err_clear", 16'h3002, 6);
    n_vec++;
    if (err_count !== 8'd0) begin
      n_err++;
      $display("FAIL err_clear_final: got err=%0d want 0", err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    mosi_buffer = 16'h1055;
    mosi_buffer_valid = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if ({setpoint, kp, ctrl_enable, cmd_update, cmd_error, err_count} !== {12'h000, 12'h001, 3'b000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_mid: got sp=%h kp=%h en=%b upd=%b err=%0d want sp=000 kp=001 en=0 upd=0 err=0",
               setpoint, kp, ctrl_enable, cmd_update, err_count);
    end
    @(negedge sys_clk);
    n_vec++;
    if (cmd_update !== 1'b0 || setpoint !== 12'h000) begin
      n_err++;
      $display("FAIL reset_hold: got upd=%b sp=%h want upd=0 sp=000", cmd_update, setpoint);
    end
    sys_reset = 1'b0;
    run_frame("reprocess", 16'h1055, 8);
  endtask

`ifdef SPI_CMD_SHADOW_EN
  task automatic test_commit();
    test_reset();
    send_frame("shadow_sp", 16'h1200, 6);
    send_frame("shadow_ctrl", 16'h3001, 6);
    send_frame("commit", 16'h4000, 6);
  endtask
`else
  task automatic test_illegal_commit();
    test_reset();
    send_frame("commit_illegal", 16'h4000, 6);
    n_vec++;
    if (err_count !== 8'd1) begin
      n_err++;
      $display("FAIL commit_errcnt: got err=%0d want 1", err_count);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'($urandom_range(0, 4));
      send_frame("random", w, 6 + $urandom_range(0, 4));
    end
  endtask

  task automatic test_back_to_back();
    send_frame("b2b_sp", 16'h1001, 6);
    send_frame("b2b_kp", 16'h2FFF, 6);
    send_frame("b2b_nop", 16'h0ABC, 6);
    send_frame("b2b_en", 16'h3001, 6);
  endtask

  initial begin
    total_err_pulses = 0;
    model_reset();
    test_reset();
    test_setpoint();
    test_long_hold();
    test_error_saturation();
    test_reset_mid_frame();
`ifdef SPI_CMD_SHADOW_EN
    test_commit();
`else
    test_illegal_commit();
`endif
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Consumes completed SPI receive words (`mosi_buffer` / `mosi_buffer_valid`) from the SPI MOSI front end and turns them into register writes for the P-controller datapath: setpoint, proportional gain and control enable. It synchronises the word-valid level into `sys_clk` and detects one frame per valid assertion. It decodes a 4-bit opcode, updates the control registers and flags illegal commands.

## Interface
- `WIDTH`, 16: SPI word width. Must be ≥ 8. Bits `[WIDTH-1:WIDTH-4]` are the opcode; bits `[WIDTH-5:0]` are the data field (`DATA_W = WIDTH-4`).
- `KP_RESET`, 1: reset value of `kp`.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_reset`  in  1  asynchronous, active-high reset.
- `mosi_buffer`  in  WIDTH  received word. Stable while `mosi_buffer_valid` is high.
- `mosi_buffer_valid`  in  1  level from the SPI clock domain. Asynchronous to `sys_clk`.
- `setpoint`  out  DATA_W  controller setpoint. Reset 0.
- `kp`  out  DATA_W  proportional gain. Reset `KP_RESET`.
- `ctrl_enable`  out  1  controller enable. Reset 0.
- `cmd_update`  out  1  one-cycle pulse when any output register changes due to a command. Reset 0.
- `cmd_error`  out  1  one-cycle pulse on an illegal opcode. Reset 0.
- `err_count`  out  8  count of illegal opcodes; saturates at 255. Reset 0.

## Operation
- `mosi_buffer_valid` passes through a 2-flop synchroniser (`v_s1`, `v_s2`, both reset to 0). A rising edge of `v_s2` arms one frame.
- FSM states: IDLE, CAPTURE, APPLY, WAIT_LOW. Reset state is IDLE.
  - IDLE: on a `v_s2` rising edge, go to CAPTURE.
  - CAPTURE: latch `mosi_buffer` into the frame register; go to APPLY.
  - APPLY: decode the frame, write registers, drive pulses; go to WAIT_LOW.
  - WAIT_LOW: stay until `v_s2`==0, then go to IDLE.
- Opcodes:
  - 0x0 NOP: no change; no pulses.
  - 0x1: `setpoint` ← data.
  - 0x2: `kp` ← data.
  - 0x3 CTRL:
    - `ctrl_enable` ← data[0].
    - data[1]=1 clears `err_count` to 0.
  - 0x4 COMMIT: see Configuration.
  - All other opcodes are illegal: `cmd_error` pulses and `err_count` increments, saturating at 255.
- `cmd_update` pulses on opcodes 0x1–0x3 even when the written value equals the old value.
- CTRL with data[1]=1 clears `err_count` and does not count as an error.
- A valid that stays high for many cycles yields exactly one frame. A new frame requires `v_s2` to fall and rise again.
- `v_s2` falling during CAPTURE or APPLY: the frame completes normally, because the word is already latched.
- Reset mid-frame: all outputs and the FSM return to reset values immediately. A valid level still high after reset deassertion is accepted as one new frame, since the synchroniser restarts from 0.

## Timing
- Edge E0 is the first `sys_clk` edge that samples `mosi_buffer_valid`=1 into `v_s1`.
  - E1: `v_s2`=1.
  - E2: FSM enters CAPTURE.
  - E3: frame register loaded, FSM enters APPLY.
  - E4: output registers hold their new values; `cmd_update`/`cmd_error` are high for the cycle after E4.
- Latency from valid to output is 5 `sys_clk` edges.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum `mosi_buffer_valid` low time between frames is 2 `sys_clk` cycles.
- `mosi_buffer` must remain stable until E3.

## Configuration
- `SPI_CMD_SHADOW_EN` defined:
  - Opcodes 0x1–0x3 write shadow registers. Visible outputs are unchanged and `cmd_update` does not pulse.
  - COMMIT (0x4) copies all shadows to the outputs in one cycle and pulses `cmd_update`.
  - The `err_count` clear bit in CTRL acts immediately.
  - Shadows reset to the same values as the outputs.
- `SPI_CMD_SHADOW_EN` undefined: writes apply directly to the outputs, and 0x4 is illegal.

## Structure
- Package `spi_cmd_pkg`:
  - Opcode enum: `OP_NOP`, `OP_SETPOINT`, `OP_KP`, `OP_CTRL`, `OP_COMMIT`.
  - FSM state enum.
  - `OPC_W`=4.
  - `ERR_CNT_W`=8.
- Sub-module `spi_valid_sync`: 2-flop synchroniser plus rising-edge detector, with async active-high reset. It outputs the `v_s2` level and a `rise` pulse.

## Test plan
- Reset, then send frame 0x1ABC → `setpoint`=0xABC at E4, one `cmd_update` pulse; `kp`=1 and `ctrl_enable`=0 are unchanged.
- Hold valid high for 50 cycles with frame 0x2123 → `kp`=0x123, exactly one `cmd_update`, FSM remains in WAIT_LOW until valid falls.
- Send 300 frames of 0xF000 → `cmd_error` pulses 300 times, `err_count`=255. Then send 0x3002 → `err_count`=0, `ctrl_enable`=0.
- Assert `sys_reset` during APPLY of 0x1055 → `setpoint`=0 and no pulse. After release with valid still high, the frame is reprocessed: `setpoint`=0x055.
- With the macro defined:
  - Send 0x1200 then 0x3001 → outputs stay at their reset values.
  - Then send 0x4000 → `setpoint`=0x200 and `ctrl_enable`=1 in the same cycle, with one `cmd_update`.
- With the macro undefined: send 0x4000 → `cmd_error` pulses and `err_count`=1.
